lsu_subword_rmw: RTL and testbench

Load/store unit between the single-cycle RV32I core's execute stage and the data port of the unified 16 KB byte-addressed RAM. It turns the core's RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned accesses on the RAM data port. It performs byte-lane extraction and sign or zero extension for loads, and read-modify-write for sub-word stores. While an access is in flight it stalls the core; misaligned, out-of-range and illegal-funct3 accesses are reported as faults.

---
 rtl/lsu_subword_rmw.sv | 156 +++++++++++++++
 tb/tb_lsu_subword_rmw.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_rmw.sv
// RV32I load/store unit: word-aligned RAM accesses, load lane extraction with
// sign/zero extension, read-modify-write for byte and halfword stores.
module lsu_subword_rmw #(
    parameter int unsigned MEM_SIZE = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]  state;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        fault_q;
    logic [15:0] wdata_q;

    logic [31:0] aligned_addr;
    logic        req_fault;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign aligned_addr = {req_addr[31:2], 2'b00};

    // Stores only accept B/H/W; the unsigned encodings are load-only.
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            3'b000: req_fault = 1'b0;
            3'b001: req_fault = req_addr[0];
            3'b010: req_fault = (req_addr[1:0] != 2'b00);
            3'b100: req_fault = req_we;
            3'b101: req_fault = req_we | req_addr[0];
            default: req_fault = 1'b1;
        endcase
        if (aligned_addr >= 32'(MEM_SIZE))
            req_fault = 1'b1;
    end

    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0: lane_byte = mem_rdata[7:0];
            2'd1: lane_byte = mem_rdata[15:8];
            2'd2: lane_byte = mem_rdata[23:16];
            2'd3: lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
        lane_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            3'b000: load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b001: load_val = {{16{lane_half[15]}}, lane_half};
            3'b100: load_val = {24'd0, lane_byte};
            3'b101: load_val = {16'd0, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lane_q    <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            wdata_q   <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lane_q   <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        fault_q  <= req_fault;
                        wdata_q  <= req_wdata[15:0];
                        mem_addr <= aligned_addr;
                        if (req_fault) begin
                            state <= S_RESP;
                        end else if (!req_we) begin
                            state <= S_LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            // Full-word store data goes straight to the write register.
                            mem_wdata <= req_wdata;
                            state     <= S_WRITE;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata <= load_val;
                    state <= S_RESP;
                end
                S_WRITE:  state <= S_RESP;
                S_RMW_RD: begin
                    mem_wdata <= merged;
                    state     <= S_RMW_WR;
                end
                S_RMW_WR: state <= S_RESP;
                S_RESP:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign stall       = ((state == S_IDLE) & req_valid) |
                         ((state != S_IDLE) & (state != S_RESP));
    assign mem_read    = (state == S_LOAD) | (state == S_RMW_RD);
    assign mem_write   = ((state == S_WRITE) | (state == S_RMW_WR)) & ~rst;
    assign rdata_valid = (state == S_RESP) & ~fault_q & ~we_q;
    assign fault       = (state == S_RESP) & fault_q;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Self-checking bench for lsu_subword_rmw: directed plan plus random requests
// checked against a byte-array memory model.
module tb_lsu_subword_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    logic [31:0] ram [0:4095];
    logic [7:0]  exp_mem [0:16383];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    lsu_subword_rmw #(.MEM_SIZE(16384)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[13:2]];
    always @(posedge clk)
        if (mem_write) ram[mem_addr[13:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int unsigned a);
        int unsigned base = a & ~32'd3;
        return {exp_mem[base+3], exp_mem[base+2], exp_mem[base+1], exp_mem[base]};
    endfunction

    // One complete request, from the first IDLE cycle through RESP.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int unsigned size, n_stall, n_rd, n_wr, n_rv, n_f, addr_bad, resp_cyc;
        bit          uns, bad, done;
        logic [31:0] val, resp_rdata, base;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        uns  = f3[2];
        base = addr & ~32'd3;
        bad  = (f3[1:0] == 2'd3) || (uns && size == 4) || (we && uns) ||
               ((addr % size) != 0) || (base >= 32'd16384);

        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        n_stall = 0; n_rd = 0; n_wr = 0; n_rv = 0; n_f = 0;
        addr_bad = 0; resp_cyc = 0; done = 0; resp_rdata = '0;
        for (int c = 0; c < 8 && !done; c++) begin
            #1;
            if (stall) n_stall++;
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if ((mem_read || mem_write) && mem_addr !== base) addr_bad++;
            if (rdata_valid) n_rv++;
            if (fault) n_f++;
            if (!stall) begin
                done = 1; resp_cyc = c; resp_rdata = rdata;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!done) check("timeout", 32'd0, 32'd1);

        if (!bad && !we) begin
            val = '0;
            for (int unsigned k = 0; k < size; k++)
                val |= 32'(exp_mem[addr+k]) << (8*k);
            if (!uns && size < 4 && val[8*size-1])
                val |= 32'hFFFF_FFFF << (8*size);
            exp_rdata = val;
        end
        if (!bad && we)
            for (int unsigned k = 0; k < size; k++)
                exp_mem[addr+k] = wd[8*k +: 8];

        check("stall_cycles", n_stall, bad ? 1 : (we && size < 4) ? 3 : 2);
        check("resp_cycle",   resp_cyc, bad ? 1 : (we && size < 4) ? 3 : 2);
        check("mem_reads",    n_rd, (bad || (we && size == 4)) ? 0 : 1);
        check("mem_writes",   n_wr, (bad || !we) ? 0 : 1);
        check("mem_addr",     addr_bad, 0);
        check("fault_pulse",  n_f, bad ? 1 : 0);
        check("rvalid_pulse", n_rv, (!bad && !we) ? 1 : 0);
        check("rdata",        resp_rdata, exp_rdata);
        if (!bad && we) check("ram_word", ram[base[13:2]], model_word(base));
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            ram[i] = r;
            for (int k = 0; k < 4; k++) exp_mem[4*i+k] = r[8*k +: 8];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; exp_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_enables", {mem_read, mem_write, rdata_valid, fault}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1, 3'b010, 32'h100, 32'hDEADBEEF);
        do_req(0, 3'b010, 32'h100, 32'h0);
        check("lw_0x100", exp_rdata, 32'hDEADBEEF);
        do_req(0, 3'b000, 32'h103, 32'h0);
        check("lb_0x103", exp_rdata, 32'hFFFFFFDE);
        do_req(0, 3'b100, 32'h103, 32'h0);
        check("lbu_0x103", exp_rdata, 32'h000000DE);
        do_req(0, 3'b001, 32'h102, 32'h0);
        check("lh_0x102", exp_rdata, 32'hFFFFDEAD);
        do_req(0, 3'b101, 32'h100, 32'h0);
        check("lhu_0x100", exp_rdata, 32'h0000BEEF);

        do_req(1, 3'b010, 32'h200, 32'h11223344);
        do_req(1, 3'b000, 32'h201, 32'h000000AB);
        check("sb_word", model_word(32'h200), 32'h1122AB44);
        do_req(1, 3'b001, 32'h202, 32'h0000CAFE);
        check("sh_word", model_word(32'h200), 32'hCAFEAB44);

        do_req(0, 3'b010, 32'h102, 32'h0);
        do_req(1, 3'b001, 32'h301, 32'h1234);
        do_req(0, 3'b000, 32'h4000, 32'h0);
        do_req(0, 3'b011, 32'h100, 32'h0);

        // Reset during RMW_WR: the store must leave no trace.
        do_req(1, 3'b010, 32'h200, 32'h11223344);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h200; req_wdata = 32'h55;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rmw_no_write", mem_write, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        exp_rdata = '0;
        #1;
        check("rst_rmw_idle", {stall, fault, rdata_valid, mem_read}, 0);
        @(negedge clk);
        do_req(0, 3'b010, 32'h200, 32'h0);
        check("rst_rmw_word", exp_rdata, 32'h11223344);

        do_req(1, 3'b010, 32'h10, 32'h5);
        do_req(0, 3'b010, 32'h10, 32'h0);
        check("b2b_lw", exp_rdata, 32'h5);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'h3FF0 + $urandom_range(0, 40)
                                            : $urandom_range(0, 1023);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
